// File: rtl/mm_result_wb_writer.sv
// Drains the matmul result stream into a small FIFO and writes each word to memory
// over Wishbone classic. Optional ack timeout: define MMWR_ACK_TIMEOUT_EN.
module mm_result_wb_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 6,
    parameter int ACK_TMO    = 255
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_base,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             s_tvalid,
    input  logic [31:0]      s_tdata,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             err_tmo,
    output logic             irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW:0]      wptr, rptr, fifo_count;
    logic [31:0]      base;
    logic [LEN_W-1:0] len, rx_cnt, wr_cnt;
    logic             push, pop;

    assign fifo_count = wptr - rptr;
    assign s_tready   = (state == RUN) && (fifo_count < DEPTH) && (rx_cnt < len);
    assign push       = s_tvalid && s_tready;
    // ack only counts while our own cycle is open
    assign pop        = wbm_cyc_o && wbm_ack_i;
    assign busy       = (state != IDLE);

`ifdef MMWR_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TMO + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign err_tmo = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{ACK_TMO[0]};
`endif

    always_ff @(posedge axis_clk) begin
        if (push) mem[wptr[AW-1:0]] <= s_tdata;
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            base      <= '0;
            len       <= '0;
            rx_cnt    <= '0;
            wr_cnt    <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            done      <= 1'b0;
            err_len   <= 1'b0;
            irq       <= 1'b0;
`ifdef MMWR_ACK_TIMEOUT_EN
            err_tmo   <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            irq <= 1'b0;
            if (push) begin
                wptr   <= wptr + 1'b1;
                rx_cnt <= rx_cnt + 1'b1;
                if (s_tlast != (rx_cnt == len - LEN_W'(1))) err_len <= 1'b1;
            end
            if (pop) begin
                rptr      <= rptr + 1'b1;
                wr_cnt    <= wr_cnt + 1'b1;
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                wbm_sel_o <= 4'h0;
            end
            case (state)
                IDLE: if (cfg_start) begin
                    base    <= {cfg_base[31:2], 2'b00};
                    len     <= cfg_len;
                    done    <= 1'b0;
                    err_len <= 1'b0;
`ifdef MMWR_ACK_TIMEOUT_EN
                    err_tmo <= 1'b0;
`endif
                    rx_cnt  <= '0;
                    wr_cnt  <= '0;
                    wptr    <= '0;
                    rptr    <= '0;
                    state   <= (cfg_len == '0) ? FIN : RUN;
                end
                RUN: begin
                    if (wr_cnt == len) begin
                        state <= FIN;
                    end else if (!wbm_cyc_o && fifo_count != '0) begin
                        // a gap cycle always follows an ack, since cyc was cleared on it
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_sel_o <= 4'hF;
                        wbm_adr_o <= base + {{(30-LEN_W){1'b0}}, wr_cnt, 2'b00};
                        wbm_dat_o <= mem[rptr[AW-1:0]];
`ifdef MMWR_ACK_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                FIN: begin
                    irq   <= 1'b1;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef MMWR_ACK_TIMEOUT_EN
            if (wbm_stb_o && !wbm_ack_i) begin
                if (tmo_cnt == TW'(ACK_TMO - 1)) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    wbm_sel_o <= 4'h0;
                    err_tmo   <= 1'b1;
                    wptr      <= '0;
                    rptr      <= '0;
                    state     <= FIN;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_mm_result_wb_writer.sv
// Directed bench for mm_result_wb_writer: Wishbone slave model with programmable
// ack delay, write log, and hand-computed address/data expectations.
module tb_mm_result_wb_writer;
    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_base = '0;
    logic [5:0]  cfg_len = '0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic        busy, done, err_len, err_tmo, irq;

    mm_result_wb_writer #(.FIFO_DEPTH(4), .LEN_W(6), .ACK_TMO(255)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
        .busy(busy), .done(done), .err_len(err_len), .err_tmo(err_tmo), .irq(irq)
    );

    always #5 axis_clk = ~axis_clk;

    int pass_cnt = 0, tot_cnt = 0;
    int ack_dly = 0, wcnt = 0, irq_cnt = 0, stall_cnt = 0;
    bit ack_off = 1'b0, abort = 1'b0;
    logic [31:0] log_adr[$], log_dat[$];
    logic [4:0]  log_sw[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Slave model: the ack raised here is sampled at the next posedge, so log the
    // request as it stands now.
    always @(negedge axis_clk) begin
        if (irq) irq_cnt++;
        if (s_tvalid && !s_tready && busy) stall_cnt++;
        if (wbm_stb_o && !wbm_ack_i && !ack_off) begin
            if (wcnt >= ack_dly) begin
                wbm_ack_i = 1'b1;
                log_adr.push_back(wbm_adr_o);
                log_dat.push_back(wbm_dat_o);
                log_sw.push_back({wbm_we_o, wbm_sel_o});
            end else wcnt++;
        end else begin
            wbm_ack_i = 1'b0;
            wcnt = 0;
        end
    end

    task automatic start(input logic [31:0] b, input logic [5:0] l);
        @(negedge axis_clk);
        cfg_base = b; cfg_len = l; cfg_start = 1'b1;
        @(negedge axis_clk);
        cfg_start = 1'b0;
    endtask

    task automatic send(input int n, input int last_idx);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge axis_clk);
            s_tvalid = 1'b1; s_tdata = i + 1; s_tlast = (i == last_idx);
            t = 0;
            while (!s_tready && t < 2000 && !abort) begin
                @(negedge axis_clk);
                t++;
            end
            if (abort) break;
            if (t >= 2000) begin
                chk("send_tmo", t, 0);
                break;
            end
            @(posedge axis_clk);
        end
        @(negedge axis_clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 3000) begin
            @(negedge axis_clk);
            t++;
        end
        if (t >= 3000) chk({tag, "_done_tmo"}, t, 0);
        repeat (2) @(negedge axis_clk);
    endtask

    task automatic verify(input string tag, input logic [31:0] b, input int n);
        int m;
        chk({tag, "_nwr"}, log_adr.size(), n);
        m = (log_adr.size() < n) ? log_adr.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_adr%0d", tag, i), log_adr[i], b + 32'(4 * i));
            chk($sformatf("%s_dat%0d", tag, i), log_dat[i], 32'(i + 1));
            chk($sformatf("%s_sel%0d", tag, i), {27'd0, log_sw[i]}, 32'h1F);
        end
        log_adr.delete(); log_dat.delete(); log_sw.delete();
    endtask

    task automatic run_job(input string tag, input logic [31:0] b, input int n,
                           input int last_idx, input int dly);
        int i0;
        ack_dly = dly;
        i0 = irq_cnt;
        start(b, 6'(n));
        send(n, last_idx);
        wait_done(tag);
        chk({tag, "_irq"}, irq_cnt - i0, 1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int i0, t;
        // reset state
        #12;
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_we", wbm_we_o, 0);
        chk("rst_sel", wbm_sel_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_len, err_tmo}, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tready", s_tready, 0);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;

        // 1: nominal job, zero-wait ack
        run_job("j1", 32'h3800_0000, 16, 15, 0);
        verify("j1", 32'h3800_0000, 16);
        chk("j1_done", done, 1);
        chk("j1_errs", {err_len, err_tmo}, 0);

        // 2: slow slave forces backpressure
        stall_cnt = 0;
        run_job("j2", 32'h3800_0000, 16, 15, 5);
        verify("j2", 32'h3800_0000, 16);
        chk("j2_stalled", stall_cnt > 0, 1);
        chk("j2_err_len", err_len, 0);

        // 3: tlast in the wrong place
        run_job("j3", 32'h3800_0000, 16, 7, 0);
        verify("j3", 32'h3800_0000, 16);
        chk("j3_err_len", err_len, 1);
        chk("j3_done", done, 1);

        // 4: zero-length job
        i0 = irq_cnt;
        start(32'h1000_0000, 6'd0);
        chk("j4_irq_c1", irq, 0);
        chk("j4_busy_c1", busy, 1);
        @(negedge axis_clk);
        chk("j4_irq_c2", irq, 1);
        chk("j4_done", done, 1);
        repeat (3) @(negedge axis_clk);
        chk("j4_irq_once", irq_cnt - i0, 1);
        chk("j4_nwr", log_adr.size(), 0);
        chk("j4_err_len", err_len, 0);

        // 5: address wraps past 2^32
        run_job("j5", 32'hFFFF_FFF8, 4, 3, 0);
        verify("j5", 32'hFFFF_FFF8, 4);

        // 6: reset during the 6th write
        i0 = irq_cnt;
        ack_dly = 3;
        abort = 1'b0;
        start(32'h3800_0000, 6'd16);
        fork
            send(16, 15);
            begin
                t = 0;
                while (!(log_adr.size() == 5 && wbm_stb_o && !wbm_ack_i) && t < 1000) begin
                    @(negedge axis_clk);
                    #2;
                    t++;
                end
                chk("j6_reach_6th", t < 1000, 1);
                axis_rst_n = 1'b0;
                #1;
                chk("j6_cyc", wbm_cyc_o, 0);
                chk("j6_stb", wbm_stb_o, 0);
                chk("j6_busy", busy, 0);
                abort = 1'b1;
            end
        join
        repeat (3) @(negedge axis_clk);
        chk("j6_no_irq", irq_cnt - i0, 0);
        chk("j6_nwr", log_adr.size(), 5);
        log_adr.delete(); log_dat.delete(); log_sw.delete();
        abort = 1'b0;
        axis_rst_n = 1'b1;
        run_job("j7", 32'h3800_0000, 16, 15, 0);
        verify("j7", 32'h3800_0000, 16);
        chk("j7_done", done, 1);

`ifdef MMWR_ACK_TIMEOUT_EN
        // 8: slave never acks
        ack_off = 1'b1;
        i0 = irq_cnt;
        start(32'h2000_0000, 6'd4);
        send(1, -1);
        repeat (200) @(negedge axis_clk);
        chk("j8_no_tmo_yet", err_tmo, 0);
        wait_done("j8");
        chk("j8_err_tmo", err_tmo, 1);
        chk("j8_done", done, 1);
        chk("j8_irq", irq_cnt - i0, 1);
        chk("j8_cyc", wbm_cyc_o, 0);
        chk("j8_nwr", log_adr.size(), 0);
        ack_off = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
